gf3_poly_reduce_seq: RTL
========================

// Module: gf3_poly_reduce_seq
// PURPOSE
//  Sequential remainder engine over GF(3): out_rem = A mod P, one or more S - q*(P<<k) steps per clock.
//  It is the iterated, parametrised successor of the single multiply-subtract step used in the GF(3^M) datapath.
//  Typical use: reduces a double-length (2M-1 digit) product back into GF(3^M) before the pairing loop.
//  Digit encoding: 2 bits per GF(3) digit, 00=0, 01=1, 10=2, 11=illegal.
// PARAMETERS
//  M       97       degree of modulus P; remainder has M digits
//  N       2*M-1    digit count of dividend A; elaboration error unless N > M
//  UNROLL  1        reduction steps per clock; elaboration error unless (N-M) % UNROLL == 0
//  STEPS   (N-M)/UNROLL  derived (localparam), RUN cycles per job
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        asynchronous, active-low reset
//  in_valid   in   1        job request
//  in_ready   out  1        engine idle, job accepted on in_valid & in_ready
//  in_a       in   2*N      dividend, digit i at [2i+1:2i]
//  in_p       in   2*M+2    modulus incl. leading digit p_M at [2M+1:2M]
//  out_valid  out  1        result held valid until accepted
//  out_ready  in   1        consumer accepts on out_valid & out_ready
//  out_rem    out  2*M      remainder, digit i at [2i+1:2i]
//  out_err    out  1        job had an illegal digit or p_M == 0
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, out_valid=0, out_rem=0, out_err=0, counter=0, W=0; in_ready=1 after release.
//  States: IDLE -> RUN on accept; RUN -> DONE when cnt == STEPS-1; DONE -> IDLE on out_ready.
//  IDLE: in_ready=1. Accept edge loads W<=in_a and Preg<=in_p, sets cnt=0, computes err.
//  RUN, per step: d=W[N-1]; q=d*p_M (inverse of p_M equals p_M in GF(3)); W[N-1:N-1-M] -= q*Preg; then W <<= 1 digit.
//  RUN: UNROLL steps are chained combinationally per clock, and cnt increments once per clock.
//  Latency: out_valid rises exactly STEPS clocks after the accept edge (96 for the defaults). Latency does not depend on the data.
//  Entering DONE: out_rem <= top M digits of W after the final step; out_err <= err.
//  When err=1: out_rem=0, out_err=1. Latency is unchanged.
//  err is set by any 11 digit in in_a or in_p, or by p_M in {00,11}.
//  DONE: out_valid=1. out_rem and out_err are stable until the accept edge.
//  At the accept edge, out_valid and out_err clear; out_rem holds its value.
//  in_ready=0 in RUN and DONE; in_valid in those states is ignored and not queued.
//  There is no same-cycle result-accept plus new-job accept; the earliest new accept is the cycle after DONE exits.
//  A deg(A) < M job still runs STEPS cycles; leading steps have q=0.
//  Reset mid-RUN or mid-DONE aborts the job and leaves no output.
//  The GF(3) arithmetic never produces 11 from legal operands.
// STRUCTURE
//  Shared package gf3_pkg: DIGIT_W=2, encodings D0/D1/D2/DILL, functions f3_add, f3_sub, f3_mul, f3_is_illegal.
//  Shared package gf3_pkg: state enum IDLE/RUN/DONE.
//  Sub-module gf3_mulsub_row #(M): digit-wise S - q*P over M+1 digits, instantiated UNROLL times in a chain.
//  Counter width $clog2(STEPS+1). Single always block for state/cnt/W, separate combinational step chain.
// TESTING
//  1 Reset held, then released: out_valid=0, in_ready=1, out_rem=0. Assert reset mid-RUN: IDLE next cycle, no out_valid.
//  2 P=x^97+x^12+2 (196'h4...1000002), A=x^97: after 96 cycles out_rem has digit12=10, digit0=01, others 00, err=0.
//  3 A=x^50+2x^3, same P: out_rem==A[2M-1:0] after 96 cycles.
//  4 A=P*x^5 (and P*(x^95+2)): out_rem all zero.
//  5 out_ready low 10 cycles in DONE: out_rem stable, in_ready=0. in_valid pulsed during RUN is ignored.
//  6 Illegal 11 in A digit 150, or p_M=00: out_err=1, out_rem=0, latency 96.
//  7 1000 random legal jobs at UNROLL=1 and UNROLL=2 (latency 48) match the reference model with random backpressure.

Source files
------------

// File: rtl/gf3_pkg.sv
// GF(3) digit encodings, arithmetic helpers and the reduction engine state type.
// Digits are 2 bits: 00=0, 01=1, 10=2, 11=illegal.
package gf3_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t D0   = 2'b00;
  localparam digit_t D1   = 2'b01;
  localparam digit_t D2   = 2'b10;
  localparam digit_t DILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic f3_is_illegal(input digit_t a);
    return (a == DILL);
  endfunction

  function automatic digit_t f3_neg(input digit_t a);
    digit_t r;
    case (a)
      D1:      r = D2;
      D2:      r = D1;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic digit_t f3_add(input digit_t a, input digit_t b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic digit_t f3_sub(input digit_t a, input digit_t b);
    return f3_add(a, f3_neg(b));
  endfunction

  function automatic digit_t f3_mul(input digit_t a, input digit_t b);
    digit_t r;
    if (a == D0 || b == D0)             r = D0;
    else if (f3_is_illegal(a) || f3_is_illegal(b)) r = DILL;
    else if (a == D1)                   r = b;
    else if (b == D1)                   r = a;
    else                                r = D1;
    return r;
  endfunction

endpackage

// File: rtl/gf3_mulsub_row.sv
// One reduction row: digit-wise S - q*P across M+1 GF(3) digits.
module gf3_mulsub_row
  import gf3_pkg::*;
#(
  parameter int unsigned M = 97
) (
  input  logic [2*M+1:0] i_s,
  input  digit_t         i_q,
  input  logic [2*M+1:0] i_p,
  output logic [2*M+1:0] o_d
);

  always_comb begin
    o_d = '0;
    for (int unsigned i = 0; i <= M; i++) begin
      o_d[2*i +: 2] = f3_sub(i_s[2*i +: 2], f3_mul(i_q, i_p[2*i +: 2]));
    end
  end

endmodule

// File: rtl/gf3_poly_reduce_seq.sv
// Sequential GF(3) polynomial remainder engine: out_rem = A mod P,
// UNROLL long-division steps per clock, fixed latency of STEPS clocks.
module gf3_poly_reduce_seq
  import gf3_pkg::*;
#(
  parameter int unsigned M      = 97,
  parameter int unsigned N      = 2*M-1,
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_a,
  input  logic [2*M+1:0]   in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*M-1:0]   out_rem,
  output logic             out_err
);

  if (N <= M) begin : g_bad_n
    $error("gf3_poly_reduce_seq: N must exceed M");
  end
  if (UNROLL == 0 || ((N - M) % UNROLL) != 0) begin : g_bad_unroll
    $error("gf3_poly_reduce_seq: (N-M) must be a nonzero multiple of UNROLL");
  end

  localparam int unsigned STEPS = (N - M) / UNROLL;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*N-1:0]       r_w;
  logic [2*M+1:0]       r_p;
  logic                 r_err;
  logic                 r_valid;
  logic                 r_out_err;
  logic [2*M-1:0]       r_rem;

  logic                 w_in_err;
  logic [2*N-1:0]       w_stage [UNROLL+1];
  logic [UNROLL-1:0]    w_top_nz_v;
  logic                 w_top_nz;
  logic                 w_job_err;

  always_comb begin
    w_in_err = f3_is_illegal(in_p[2*M+1 -: 2]) || (in_p[2*M+1 -: 2] == D0);
    for (int unsigned i = 0; i < N; i++) begin
      w_in_err = w_in_err | f3_is_illegal(in_a[2*i +: 2]);
    end
    for (int unsigned i = 0; i <= M; i++) begin
      w_in_err = w_in_err | f3_is_illegal(in_p[2*i +: 2]);
    end
  end

  // Each stage cancels the leading digit (q = d*p_M since p_M is its own
  // inverse), then shifts left one digit. The cancelled digit is always 0 for
  // legal operands; a nonzero value only arises when err is already set.
  assign w_stage[0] = r_w;

  for (genvar u = 0; u < UNROLL; u++) begin : g_step
    digit_t         w_q;
    logic [2*M+1:0] w_row;

    assign w_q = f3_mul(w_stage[u][2*N-1 -: 2], r_p[2*M+1 -: 2]);

    gf3_mulsub_row #(
      .M (M)
    ) u_row (
      .i_s (w_stage[u][2*N-1 -: 2*(M+1)]),
      .i_q (w_q),
      .i_p (r_p),
      .o_d (w_row)
    );

    assign w_top_nz_v[u] = |w_row[2*M+1 -: 2];

    if (N - M > 1) begin : g_shift_long
      assign w_stage[u+1] = {w_row[2*M-1:0], w_stage[u][2*(N-M-1)-1:0], 2'b00};
    end else begin : g_shift_short
      assign w_stage[u+1] = {w_row[2*M-1:0], 2'b00};
    end
  end

  assign w_top_nz  = |w_top_nz_v;
  assign w_job_err = r_err | w_top_nz;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (r_cnt == CNT_W'(STEPS - 1)) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_w       <= '0;
      r_p       <= '0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_out_err <= 1'b0;
      r_rem     <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_w   <= in_a;
            r_p   <= in_p;
            r_cnt <= '0;
            r_err <= w_in_err;
          end
        end
        RUN: begin
          r_w   <= w_stage[UNROLL];
          r_cnt <= r_cnt + CNT_W'(1);
          r_err <= w_job_err;
          if (w_state_nxt == DONE) begin
            r_valid   <= 1'b1;
            r_out_err <= w_job_err;
            r_rem     <= w_job_err ? '0 : w_stage[UNROLL][2*N-1 -: 2*M];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_valid   <= 1'b0;
            r_out_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_valid;
  assign out_err   = r_out_err;
  assign out_rem   = r_rem;

endmodule
